// File: rtl/data_gen_pkg.sv
// data_gen_pkg: shared states, pattern constants and seed helper for the FT245 traffic source.
package data_gen_pkg;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_e;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int PATTERN_INC = 0;
  localparam int PATTERN_LFSR = 1;
  function automatic logic [31:0] seed_word(input int pattern, input logic [31:0] seed);
    return (pattern == PATTERN_LFSR && seed == '0) ? 32'h1 : seed;
  endfunction
endpackage

// File: rtl/data_gen_pattern_step.sv
// pattern_step: next test word from the current one, shared with data_check.
module pattern_step
  import data_gen_pkg::*;
#(
  parameter int PATTERN = PATTERN_INC
) (
  input  logic [31:0] cur,
  output logic [31:0] nxt
);
  always_comb nxt = (PATTERN == PATTERN_LFSR) ? ((cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0)) : cur + 32'd1;
endmodule

// File: rtl/data_gen.sv
// data_gen: bursty deterministic 32-bit word source for the FT245 tx port, with run/progress LEDs.
module data_gen
  import data_gen_pkg::*;
#(
  parameter int          BURST_LEN    = 256,
  parameter int          GAP_CYCLES   = 16,
  parameter int          PATTERN      = PATTERN_INC,
  parameter logic [31:0] SEED         = 32'h0000_0000,
  parameter int          LED_DIV_LOG2 = 20
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enable,
  input  logic        tx_ready,
  output logic        tx_write,
  output logic [31:0] tx_data,
  output logic [31:0] word_count,
  output logic        busy,
  output logic [1:0]  evm_led
);
  state_e      state_q, state_d, exit_to;
  logic [15:0] burst_q, burst_d;
  logic [31:0] gap_q, gap_d, data_q, data_d, count_q, count_d, data_nxt;
  logic        led_q, led_d, accept, last_word, gap_done;
  pattern_step #(.PATTERN(PATTERN)) u_step (.cur(data_q), .nxt(data_nxt));
  always_comb begin
    accept     = (state_q == BURST) & tx_ready;
    tx_write   = accept & ~rst;
    last_word  = accept & (burst_q == 16'(BURST_LEN - 1));
    gap_done   = gap_q == 32'(GAP_CYCLES - 1);
    exit_to    = enable ? BURST : IDLE;
    data_d     = accept ? data_nxt : data_q;
    count_d    = accept ? count_q + 32'd1 : count_q;
    led_d      = led_q ^ (accept & (count_d[LED_DIV_LOG2-1:0] == '0));
    burst_d    = (state_q == BURST && !last_word) ? burst_q + 16'(accept) : '0;
    gap_d      = (state_q == GAP && !gap_done) ? gap_q + 32'd1 : '0;
    state_d    = state_q == IDLE  ? exit_to :
                 state_q == BURST ? (!last_word ? BURST : (GAP_CYCLES > 0) ? GAP : exit_to) :
                 state_q == GAP   ? (gap_done ? exit_to : GAP) : IDLE;
    tx_data    = data_q;
    word_count = count_q;
    busy       = state_q != IDLE;
    evm_led    = {led_q, busy};
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      gap_q   <= '0;
      data_q  <= seed_word(PATTERN, SEED);
      count_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      count_q <= count_d;
      led_q   <= led_d;
    end
  end
endmodule

// File: tb/tb_data_gen.sv
// tb_data_gen: three data_gen configurations against a schedule-level reference model.
module tb_data_gen;
  localparam int          BL[3] = '{4, 5, 3};
  localparam int          GP[3] = '{2, 0, 1};
  localparam int          PT[3] = '{0, 1, 0};
  localparam int          LG[3] = '{2, 3, 2};
  localparam logic [31:0] SD[3] = '{32'h0, 32'h0, 32'hFFFF_FFFE};
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, tx_ready = 1'b0;
  logic        tw[3], bz[3];
  logic [31:0] td[3], wc[3];
  logic [1:0]  led[3];
  bit          m_idle[3];
  int          m_left[3], m_gap[3];
  logic [31:0] m_data[3], m_cnt[3];
  logic        m_led[3];
  logic [31:0] acc[3][$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    data_gen #(.BURST_LEN(BL[g]), .GAP_CYCLES(GP[g]), .PATTERN(PT[g]), .SEED(SD[g]), .LED_DIV_LOG2(LG[g])) dut (
      .clk_in(clk), .rst(rst), .enable(enable), .tx_ready(tx_ready), .tx_write(tw[g]),
      .tx_data(td[g]), .word_count(wc[g]), .busy(bz[g]), .evm_led(led[g]));
  end
  function automatic logic [31:0] next_word(input int p, input logic [31:0] w);
    if (p == 1) return w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
    return w + 32'd1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_idle[i] = 1; m_left[i] = 0; m_gap[i] = 0; m_cnt[i] = 0; m_led[i] = 0;
        m_data[i] = (PT[i] == 1 && SD[i] == 0) ? 32'h1 : SD[i];
      end else if (m_idle[i]) begin
        if (enable) begin m_idle[i] = 0; m_left[i] = BL[i]; end
      end else if (m_left[i] > 0) begin
        if (tx_ready) begin
          m_data[i] = next_word(PT[i], m_data[i]);
          m_cnt[i]++;
          if (m_cnt[i] % (32'd1 << LG[i]) == 0) m_led[i] = ~m_led[i];
          m_left[i]--;
          if (m_left[i] == 0) begin
            if (GP[i] > 0) m_gap[i] = GP[i];
            else if (enable) m_left[i] = BL[i];
            else m_idle[i] = 1;
          end
        end
      end else begin
        m_gap[i]--;
        if (m_gap[i] == 0) begin
          if (enable) m_left[i] = BL[i];
          else m_idle[i] = 1;
        end
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx_write[%0d]", i), 32'(tw[i]), 32'(!m_idle[i] && m_left[i] > 0 && tx_ready && !rst));
      chk($sformatf("tx_data[%0d]", i), td[i], m_data[i]);
      chk($sformatf("word_count[%0d]", i), wc[i], m_cnt[i]);
      chk($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(!m_idle[i]));
      chk($sformatf("evm_led[%0d]", i), 32'(led[i]), 32'({m_led[i], !m_idle[i]}));
      if (tw[i]) acc[i].push_back(td[i]);
    end
  endtask
  task automatic cyc(input logic r, input logic e, input logic t);
    @(posedge clk);
    model_step();
    #1 rst = r; enable = e; tx_ready = t;
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) acc[i].delete();
  endtask
  initial begin
    do_reset();
    chk("rst_seed_lfsr", td[1], 32'h1);
    chk("rst_seed_wrap", td[2], 32'hFFFF_FFFE);
    chk("rst_count", wc[0], 32'h0);
    for (int k = 0; k < 40 && acc[2].size() < 4; k++) cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("wrap_count", wc[2], 32'd4);
    chk("wrap_led_toggle", 32'(led[2][1]), 32'd1);
    chk("wrap_w0", acc[2][0], 32'hFFFF_FFFE);
    chk("wrap_w1", acc[2][1], 32'hFFFF_FFFF);
    chk("wrap_w2", acc[2][2], 32'h0000_0000);
    for (int k = 0; k < 40 && acc[0].size() < 8; k++) cyc(0, 1, 1);
    chk("two_bursts_size", 32'(acc[0].size()), 32'd8);
    for (int k = 0; k < 8 && k < acc[0].size(); k++) chk($sformatf("two_bursts_w%0d", k), acc[0][k], 32'(k));
    cyc(0, 1, 1);
    chk("two_bursts_count", wc[0], 32'd8);
    chk("lfsr_w0", acc[1][0], 32'h0000_0001);
    chk("lfsr_w1", acc[1][1], 32'h8020_0003);
    chk("lfsr_w2", acc[1][2], 32'hC030_0002);
    do_reset();
    for (int k = 0; k < 40; k++) cyc(0, 1, k % 2 == 0);
    chk("toggle_progress", 32'(acc[0].size() >= 10), 32'd1);
    for (int k = 0; k < acc[0].size(); k++) chk($sformatf("toggle_seq%0d", k), acc[0][k], 32'(k));
    do_reset();
    for (int k = 0; k < 20 && acc[0].size() < 2; k++) cyc(0, 1, 1);
    for (int k = 0; k < 10; k++) cyc(0, 0, 1);
    chk("drop_enable_words", 32'(acc[0].size()), 32'd4);
    chk("drop_enable_busy", 32'(bz[0]), 32'd0);
    chk("drop_enable_led0", 32'(led[0][0]), 32'd0);
    do_reset();
    for (int k = 0; k < 20 && acc[0].size() < 2; k++) cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk("rst_mid_tx_write", 32'(tw[0]), 32'd0);
    for (int i = 0; i < 3; i++) acc[i].delete();
    cyc(0, 1, 1);
    chk("rst_mid_count", wc[0], 32'd0);
    chk("rst_mid_data", td[0], 32'd0);
    for (int k = 0; k < 20 && acc[1].size() < 1; k++) cyc(0, 1, 1);
    chk("rst_mid_restart0", acc[0].size() > 0 ? acc[0][0] : 32'hDEAD_BEEF, 32'd0);
    chk("rst_mid_restart1", acc[1].size() > 0 ? acc[1][0] : 32'hDEAD_BEEF, 32'd1);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
